uart_transmitter: RTL
=====================

// Module: uart_transmitter
// PURPOSE
//  Serialises one parallel byte per request into an asynchronous UART frame on Serial_out.
//  Runs from the same Sample_clk as the UART receiver: each bit is held for SAMPLES_PER_BIT clocks.
//  Frame: start (0), WORD_SIZE data bits LSB first, optional parity, one stop (1).
//  Sits opposite the receiver; looping Serial_out to Serial_in must return the sent byte.
// PARAMETERS
//  WORD_SIZE        8  data bits per frame
//  SAMPLES_PER_BIT  8  Sample_clk cycles per serial bit; power of two, >= 2
// PORTS
//  Sample_clk     in   1          single clock, all logic on rising edge
//  rst            in   1          synchronous, active-high reset
//  XMT_data       in   WORD_SIZE  byte to send; sampled only on acceptance
//  Load_XMT       in   1          request; accepted when Load_XMT && XMT_ready
//  XMT_ready      out  1          high only in IDLE; transmitter can accept a byte
//  XMT_done       out  1          one-cycle pulse on last cycle of stop bit
//  Serial_out     out  1          serial line, idle high
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, Serial_out=1, XMT_ready=1, XMT_done=0, counters and datareg=0.
//  Reset mid-frame aborts it: line returns to 1 on the next cycle; no XMT_done.
//  States: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
//  IDLE: Serial_out=1; on acceptance capture XMT_data into XMT_shftreg, clear counters, go START.
//  Latency: Serial_out falls on the first cycle after the acceptance edge.
//  START: Serial_out=0 for SAMPLES_PER_BIT cycles, then DATA.
//  DATA: Serial_out=XMT_shftreg[0]; after SAMPLES_PER_BIT cycles shift right, Bit_counter+1;
//   after WORD_SIZE bits go PARITY (if enabled) else STOP.
//  STOP: Serial_out=1 for SAMPLES_PER_BIT cycles; XMT_done=1 in the last; then IDLE.
//  Sample_counter: 0..SAMPLES_PER_BIT-1, wraps to 0 at each bit boundary; Bit_counter width clog2(WORD_SIZE)+1.
//  Load_XMT while XMT_ready=0: ignored, not queued; XMT_data changes mid-frame have no effect.
//  Back-to-back: Load_XMT held high gives one IDLE cycle between frames (stop bit = 9 cycles at default).
//  Frame length at defaults: 80 cycles, 88 with parity, plus the IDLE cycle.
//  Load_XMT and rst asserted together: rst wins, request dropped.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state after DATA, Serial_out = even parity (XOR of captured byte)
//   for SAMPLES_PER_BIT cycles; frame is WORD_SIZE+3 bits.
//  Undefined: no PARITY state, no parity logic; frame is WORD_SIZE+2 bits. Default: undefined,
//   matching the existing receiver.
// STRUCTURE
//  uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP), WORD_SIZE and SAMPLES_PER_BIT defaults,
//   shared with the receiver.
//  Split control/datapath as in the receiver: uart_transmitter holds the FSM;
//   sub-module uart_tx_datapath holds XMT_shftreg, Sample_counter, Bit_counter and exposes
//   SC_eq_last, BC_eq_word flags; FSM drives clr/inc counter, load, shift.
// TESTING
//  1 Reset: rst high 3 cycles -> Serial_out=1, XMT_ready=1, XMT_done=0; all held with Load_XMT=0.
//  2 Send 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1, each exactly 8 cycles; start edge 1 cycle after
//    acceptance; XMT_done pulses at cycle 80; XMT_ready back high at cycle 81.
//  3 Back-to-back 8'h3C then 8'hC3 with Load_XMT held -> frames separated by exactly one idle-high
//    cycle; second frame bits 0,1,1,0,0,0,0,1,1,1.
//  4 Load_XMT pulsed with 8'hFF mid-frame of 8'h00 -> ignored; only 8'h00 frame appears, line idle after.
//  5 rst asserted at cycle 30 of a frame -> Serial_out=1 next cycle, no XMT_done, new byte 8'h5A
//    then transmits correctly.
//  6 Loopback into uart receiver: bytes 8'h00, 8'hFF, 8'h96 -> RCV_datareg matches each,
//    Error1=Error2=0; with UART_TX_PARITY_EN, 8'h07 -> parity bit 1, frame 88 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default frame parameters
package uart_pkg;

  localparam int WORD_SIZE_DEF       = 8;
  localparam int SAMPLES_PER_BIT_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_datapath.sv
// rtl/uart_tx_datapath.sv - transmit shift register, sample and bit counters
module uart_tx_datapath
  import uart_pkg::*;
#(
  parameter int WORD_SIZE       = WORD_SIZE_DEF,
  parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF
) (
  input  logic                 Sample_clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] XMT_data,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 clr_cnt,
  input  logic                 inc_sample,
  output logic                 cur_bit,
  output logic                 nxt_bit,
  output logic                 SC_eq_last,
  output logic                 SC_eq_prelast,
  output logic                 BC_eq_word
);

  localparam int SCW = $clog2(SAMPLES_PER_BIT);
  localparam int BCW = $clog2(WORD_SIZE) + 1;

  logic [WORD_SIZE-1:0] XMT_shftreg_q;
  logic [SCW-1:0]       Sample_counter_q;
  logic [BCW-1:0]       Bit_counter_q;

  assign cur_bit       = XMT_shftreg_q[0];
  assign nxt_bit       = XMT_shftreg_q[1];
  assign SC_eq_last    = (Sample_counter_q == SCW'(SAMPLES_PER_BIT - 1));
  assign SC_eq_prelast = (Sample_counter_q == SCW'(SAMPLES_PER_BIT - 2));
  // High while the final data bit of the word is on the line.
  assign BC_eq_word    = (Bit_counter_q == BCW'(WORD_SIZE - 1));

  always_ff @(posedge Sample_clk) begin
    if (rst) begin
      XMT_shftreg_q    <= '0;
      Sample_counter_q <= '0;
      Bit_counter_q    <= '0;
    end else begin
      if (load) begin
        XMT_shftreg_q <= XMT_data;
      end else if (shift) begin
        XMT_shftreg_q <= {1'b0, XMT_shftreg_q[WORD_SIZE-1:1]};
      end

      if (clr_cnt) begin
        Sample_counter_q <= '0;
      end else if (inc_sample) begin
        Sample_counter_q <= SC_eq_last ? '0 : Sample_counter_q + SCW'(1);
      end

      if (clr_cnt) begin
        Bit_counter_q <= '0;
      end else if (shift) begin
        Bit_counter_q <= Bit_counter_q + BCW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmit FSM; UART_TX_PARITY_EN adds an even parity bit
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int WORD_SIZE       = WORD_SIZE_DEF,
  parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF
) (
  input  logic                 Sample_clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] XMT_data,
  input  logic                 Load_XMT,
  output logic                 XMT_ready,
  output logic                 XMT_done,
  output logic                 Serial_out
);

  uart_state_e state_q;
  logic        serial_q;
  logic        ready_q;
  logic        done_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  logic load, shift, clr_cnt, inc_sample;
  logic cur_bit, nxt_bit, SC_eq_last, SC_eq_prelast, BC_eq_word;

  assign XMT_ready  = ready_q;
  assign XMT_done   = done_q;
  assign Serial_out = serial_q;

  always_comb begin
    load       = (state_q == IDLE) && Load_XMT;
    clr_cnt    = load;
    inc_sample = (state_q != IDLE);
    shift      = (state_q == DATA) && SC_eq_last;
  end

  uart_tx_datapath #(
    .WORD_SIZE      (WORD_SIZE),
    .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
  ) u_datapath (
    .Sample_clk   (Sample_clk),
    .rst          (rst),
    .XMT_data     (XMT_data),
    .load         (load),
    .shift        (shift),
    .clr_cnt      (clr_cnt),
    .inc_sample   (inc_sample),
    .cur_bit      (cur_bit),
    .nxt_bit      (nxt_bit),
    .SC_eq_last   (SC_eq_last),
    .SC_eq_prelast(SC_eq_prelast),
    .BC_eq_word   (BC_eq_word)
  );

  // Outputs are registered, so each transition loads the value of the bit being entered.
  always_ff @(posedge Sample_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (Load_XMT) begin
            state_q  <= START;
            serial_q <= 1'b0;
            ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^XMT_data;
`endif
          end
        end
        START: begin
          if (SC_eq_last) begin
            state_q  <= DATA;
            serial_q <= cur_bit;
          end
        end
        DATA: begin
          if (SC_eq_last) begin
            if (BC_eq_word) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= PARITY;
              serial_q <= parity_q;
`else
              state_q  <= STOP;
              serial_q <= 1'b1;
`endif
            end else begin
              serial_q <= nxt_bit;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (SC_eq_last) begin
            state_q  <= STOP;
            serial_q <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (SC_eq_prelast) begin
            done_q <= 1'b1;
          end
          if (SC_eq_last) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          serial_q <= 1'b1;
          ready_q  <= 1'b1;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
